pipe_snapshot_serializer: RTL and testbench
===========================================

Name: pipe_snapshot_serializer

Overview:
- Captures a parametrised-width snapshot of the pipeline debug buses plus PC on a trigger.
- Emits the snapshot as a framed byte stream over a valid/ready handshake toward the UART TX path of the debug unit.
- Sits between the MIPS core debug outputs (control, ID/EX, EX/MEM, MEM/WB, WB, PC) and the UART transmitter.
- Supersedes fixed-width GUI packing: any snapshot width (multiple of 8), any PC width, with framing and checksum.

Parameters:
SNAP_W, 288, snapshot width in bits; must be a multiple of 8, minimum 8
PC_W, 16, PC field width in bits; must be a multiple of 8, minimum 8
HDR_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock
i_reset  in  1  synchronous reset, active-low
i_trigger  in  1  capture request; single-cycle pulse or level, sampled only in IDLE
i_snapshot  in  SNAP_W  concatenated pipeline debug data
i_pc  in  PC_W  current IF PC
i_clr_overrun  in  1  clears o_overrun
i_tx_ready  in  1  UART TX accepts a byte this cycle
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  o_tx_data is valid
o_busy  out  1  frame in progress
o_done  out  1  one-cycle pulse, frame complete
o_overrun  out  1  sticky; a trigger arrived while busy

Behaviour:
- Reset (i_reset==0 at a clk edge):
  - All outputs go to 0; state goes to IDLE; shadow registers, byte index and checksum are cleared.
  - Reset applied mid-frame aborts the frame with no o_done pulse.
  - Reset has priority over every other input.
- Frame format, sent MSB-first in every field:
  - HDR_BYTE
  - PC_W/8 PC bytes
  - SNAP_W/8 snapshot bytes
  - one checksum byte
  - Total length N = 2 + PC_W/8 + SNAP_W/8; default config gives 40 bytes.
- Checksum: bitwise XOR of all PC and snapshot bytes; the header is excluded.
- States:
  - IDLE: on i_trigger=1 at edge t, latch i_snapshot and i_pc into shadow registers and go to HDR. o_busy=1 and o_tx_valid=1 with the header byte from cycle t+1. The shadow copy is frozen for the whole frame; input changes after t have no effect.
  - HDR: on valid&&ready, go to PC with byte index 0.
  - PC: on each handshake, advance the index; after byte PC_W/8-1, reset the index and go to BODY.
  - BODY: same as PC, exiting after byte SNAP_W/8-1 to CSUM.
  - CSUM: present the accumulated checksum; on handshake go to DONE.
  - DONE: o_done=1 and o_busy=0 for exactly one cycle, o_tx_valid=0, then go to IDLE. A trigger sampled in DONE is ignored but does not set o_overrun.
- Handshake rules:
  - A byte transfers only on an edge where o_tx_valid && i_tx_ready.
  - o_tx_data is stable while o_tx_valid=1 and i_tx_ready=0.
  - o_tx_valid is never deasserted mid-frame without a transfer.
  - With i_tx_ready held at 1, bytes are delivered back-to-back, one per cycle.
  - Latency from trigger to o_done is N+1 cycles.
- Checksum accumulation: updated on each handshake of a PC or BODY byte. It is registered, so the CSUM byte shows the XOR of all prior bytes with no extra cycle.
- Overrun: i_trigger=1 in any state other than IDLE or DONE sets o_overrun=1. It stays set until i_clr_overrun=1 or reset. If set and clear occur in the same cycle, set wins.
- Index counter width: $clog2 of max(PC_W/8, SNAP_W/8), minimum 1. No wrap-around beyond the field length is permitted.
- Parameter check: elaboration fails (generate-time $error) if SNAP_W or PC_W is not a multiple of 8.

Decomposition:
- Shared package dbg_pkg:
  - state enum (IDLE, HDR, PC, BODY, CSUM, DONE)
  - HDR_BYTE default
  - function frame_len(SNAP_W, PC_W)
- One natural sub-module: snap_byte_sel, a parametrised MSB-first byte selector (shadow vector plus index in, byte out), instantiated for both the PC and snapshot fields.

Test Plan:
- Small config (SNAP_W=16, PC_W=16), i_snapshot=16'h1234, i_pc=16'h0040, ready held at 1, trigger pulse -> bytes A5,00,40,12,34,66 on consecutive cycles; o_done at trigger+7; o_busy low in that cycle.
- Same stimulus with i_tx_ready toggling 1,0,0,1,... -> identical byte sequence; o_tx_data stable during every ready=0 cycle; no byte duplicated or dropped.
- Default config: snapshot with all bytes 8'hFF, pc=16'h0000 -> 40 bytes; checksum 8'h00 (36 × FF XOR 00 = 00). Change i_snapshot after the trigger -> frame unchanged.
- Trigger again while in BODY -> o_overrun=1 and the current frame completes unchanged. i_clr_overrun and a trigger in the same cycle -> o_overrun stays 1. A later clear alone -> 0.
- Drive i_reset=0 while the 3rd byte is pending -> next cycle o_tx_valid=0, o_busy=0, no o_done. After release, a new trigger starts a fresh frame beginning with A5 and checksum restarted from 0.
- Trigger held high continuously with ready=1 -> frames repeat; the first byte of each new frame appears 2 cycles after the previous o_done-1 edge; o_overrun remains 0 only if the level is sampled in IDLE/DONE. Check that it does get set while mid-frame.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared definitions for the pipeline snapshot serializer: frame FSM states,
// the default start-of-frame marker and frame sizing helpers.
package dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PC,
        BODY,
        CSUM,
        DONE
    } state_e;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    // Header + PC bytes + snapshot bytes + checksum.
    function automatic int frame_len(input int snap_w, input int pc_w);
        return 2 + pc_w / 8 + snap_w / 8;
    endfunction

    function automatic int idx_width(input int snap_w, input int pc_w);
        int max_b;
        max_b = (pc_w / 8 > snap_w / 8) ? pc_w / 8 : snap_w / 8;
        return (max_b > 1) ? $clog2(max_b) : 1;
    endfunction

endpackage

// File: rtl/snap_byte_sel.sv
// MSB-first byte selector: index 0 returns the most significant byte of the
// shadow vector.
module snap_byte_sel #(
    parameter int W     = 16,
    parameter int IDX_W = 1
) (
    input  logic [W-1:0]     vec_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [7:0]       byte_o
);

    localparam int NB = W / 8;

    always_comb begin
        byte_o = '0;
        for (int i = 0; i < NB; i++) begin
            if (idx_i == IDX_W'(i)) begin
                byte_o = vec_i[W-1-8*i -: 8];
            end
        end
    end

endmodule

// File: rtl/pipe_snapshot_serializer.sv
// Captures a pipeline debug snapshot plus PC on trigger and streams it as a
// framed byte sequence (header, PC, snapshot, XOR checksum) over valid/ready.
module pipe_snapshot_serializer
    import dbg_pkg::*;
#(
    parameter int         SNAP_W   = 288,
    parameter int         PC_W     = 16,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_trigger,
    input  logic [SNAP_W-1:0] i_snapshot,
    input  logic [PC_W-1:0]   i_pc,
    input  logic              i_clr_overrun,
    input  logic              i_tx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);

    localparam int PC_B  = PC_W / 8;
    localparam int SNAP_B = SNAP_W / 8;
    localparam int IDX_W = idx_width(SNAP_W, PC_W);
    localparam logic [IDX_W-1:0] PC_LAST   = IDX_W'(PC_B - 1);
    localparam logic [IDX_W-1:0] SNAP_LAST = IDX_W'(SNAP_B - 1);

    if ((SNAP_W % 8) != 0 || SNAP_W < 8) begin : g_bad_snap_w
        $error("SNAP_W must be a non-zero multiple of 8");
    end
    if ((PC_W % 8) != 0 || PC_W < 8) begin : g_bad_pc_w
        $error("PC_W must be a non-zero multiple of 8");
    end

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          csum_q, csum_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          pc_byte;
    logic [7:0]          snap_byte;

    snap_byte_sel #(
        .W     (PC_W),
        .IDX_W (IDX_W)
    ) u_pc_sel (
        .vec_i  (pc_q),
        .idx_i  (idx_q),
        .byte_o (pc_byte)
    );

    snap_byte_sel #(
        .W     (SNAP_W),
        .IDX_W (IDX_W)
    ) u_snap_sel (
        .vec_i  (snap_q),
        .idx_i  (idx_q),
        .byte_o (snap_byte)
    );

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            csum_q    <= '0;
            snap_q    <= '0;
            pc_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            snap_q    <= snap_d;
            pc_q      <= pc_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        snap_d     = snap_q;
        pc_d       = pc_q;
        overrun_d  = overrun_q;
        o_tx_data  = '0;
        o_tx_valid = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_trigger) begin
                    snap_d  = i_snapshot;
                    pc_d    = i_pc;
                    csum_d  = '0;
                    idx_d   = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                o_tx_valid = 1'b1;
                o_busy     = 1'b1;
                o_tx_data  = HDR_BYTE;
                if (i_tx_ready) begin
                    idx_d   = '0;
                    state_d = PC;
                end
            end
            PC: begin
                o_tx_valid = 1'b1;
                o_busy     = 1'b1;
                o_tx_data  = pc_byte;
                if (i_tx_ready) begin
                    csum_d = csum_q ^ pc_byte;
                    if (idx_q == PC_LAST) begin
                        idx_d   = '0;
                        state_d = BODY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            BODY: begin
                o_tx_valid = 1'b1;
                o_busy     = 1'b1;
                o_tx_data  = snap_byte;
                if (i_tx_ready) begin
                    csum_d = csum_q ^ snap_byte;
                    if (idx_q == SNAP_LAST) begin
                        idx_d   = '0;
                        state_d = CSUM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            CSUM: begin
                o_tx_valid = 1'b1;
                o_busy     = 1'b1;
                o_tx_data  = csum_q;
                if (i_tx_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Set is applied after clear so a same-cycle collision leaves the flag set.
        if (i_clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (i_trigger && o_busy) begin
            overrun_d = 1'b1;
        end
    end

    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_pipe_snapshot_serializer.sv
// Bench for pipe_snapshot_serializer: a small (16/16) and a default (288/16)
// instance checked every cycle against a byte-queue frame model.
module tb_pipe_snapshot_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit started = 1'b0;

    // Small instance
    logic        a_rst, a_trig, a_clr, a_rdy;
    logic [15:0] a_snap, a_pc;
    logic [7:0]  a_data;
    logic        a_valid, a_busy, a_done, a_ovr;

    // Default instance
    logic         b_rst, b_trig, b_clr, b_rdy;
    logic [287:0] b_snap;
    logic [15:0]  b_pc;
    logic [7:0]   b_data;
    logic         b_valid, b_busy, b_done, b_ovr;

    pipe_snapshot_serializer #(.SNAP_W(16), .PC_W(16)) u_dut_a (
        .clk           (clk),
        .i_reset       (a_rst),
        .i_trigger     (a_trig),
        .i_snapshot    (a_snap),
        .i_pc          (a_pc),
        .i_clr_overrun (a_clr),
        .i_tx_ready    (a_rdy),
        .o_tx_data     (a_data),
        .o_tx_valid    (a_valid),
        .o_busy        (a_busy),
        .o_done        (a_done),
        .o_overrun     (a_ovr)
    );

    pipe_snapshot_serializer #(.SNAP_W(288), .PC_W(16)) u_dut_b (
        .clk           (clk),
        .i_reset       (b_rst),
        .i_trigger     (b_trig),
        .i_snapshot    (b_snap),
        .i_pc          (b_pc),
        .i_clr_overrun (b_clr),
        .i_tx_ready    (b_rdy),
        .o_tx_data     (b_data),
        .o_tx_valid    (b_valid),
        .o_busy        (b_busy),
        .o_done        (b_done),
        .o_overrun     (b_ovr)
    );

    // Model: mode 0 idle, 1 sending frame bytes, 2 done pulse.
    int         m_mode [2];
    int         m_pos  [2];
    int         m_len  [2];
    logic       m_ovr  [2];
    logic [7:0] mfr    [2][64];

    logic [7:0] a_log[$];
    logic [7:0] b_log[$];

    // Inputs and handshake status as seen at the last rising edge
    logic         s_a_rst, s_a_trig, s_a_clr, s_a_rdy;
    logic [15:0]  s_a_snap, s_a_pc;
    logic         s_b_rst, s_b_trig, s_b_clr, s_b_rdy;
    logic [287:0] s_b_snap;
    logic [15:0]  s_b_pc;
    logic         a_hs, b_hs, a_hold, b_hold;
    logic [7:0]   a_hs_data, b_hs_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic build_frame(input int d, input logic [287:0] snap, input int sb,
                               input logic [15:0] pc);
        logic [7:0] x;
        logic [7:0] b;
        int n;
        x = 8'h00;
        mfr[d][0] = 8'hA5;
        n = 1;
        for (int k = 0; k < 2; k++) begin
            b = pc[(1-k)*8 +: 8];
            mfr[d][n] = b;
            n = n + 1;
            x = x ^ b;
        end
        for (int k = 0; k < sb; k++) begin
            b = snap[(sb-1-k)*8 +: 8];
            mfr[d][n] = b;
            n = n + 1;
            x = x ^ b;
        end
        mfr[d][n] = x;
        m_len[d] = n + 1;
        m_pos[d] = 0;
    endtask

    task automatic model_step(input int d, input logic rst, input logic trig, input logic rdy,
                              input logic clr, input logic [287:0] snap, input int sb,
                              input logic [15:0] pc);
        logic nov;
        if (!rst) begin
            m_mode[d] = 0;
            m_pos[d]  = 0;
            m_ovr[d]  = 1'b0;
            return;
        end
        nov = m_ovr[d];
        if (clr) nov = 1'b0;
        if (trig && m_mode[d] == 1) nov = 1'b1;
        case (m_mode[d])
            0: if (trig) begin
                build_frame(d, snap, sb, pc);
                m_mode[d] = 1;
            end
            1: if (rdy) begin
                m_pos[d] = m_pos[d] + 1;
                if (m_pos[d] == m_len[d]) m_mode[d] = 2;
            end
            default: m_mode[d] = 0;
        endcase
        m_ovr[d] = nov;
    endtask

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        started   <= 1'b1;
        s_a_rst   <= a_rst;  s_a_trig <= a_trig; s_a_clr <= a_clr; s_a_rdy <= a_rdy;
        s_a_snap  <= a_snap; s_a_pc   <= a_pc;
        s_b_rst   <= b_rst;  s_b_trig <= b_trig; s_b_clr <= b_clr; s_b_rdy <= b_rdy;
        s_b_snap  <= b_snap; s_b_pc   <= b_pc;
        a_hs      <= a_rst && a_valid && a_rdy;
        b_hs      <= b_rst && b_valid && b_rdy;
        a_hs_data <= a_data;
        b_hs_data <= b_data;
        a_hold    <= a_rst && a_valid && !a_rdy;
        b_hold    <= b_rst && b_valid && !b_rdy;
    end

    always @(negedge clk) begin
        if (started) begin
            model_step(0, s_a_rst, s_a_trig, s_a_rdy, s_a_clr, {272'b0, s_a_snap}, 2, s_a_pc);
            model_step(1, s_b_rst, s_b_trig, s_b_rdy, s_b_clr, s_b_snap, 36, s_b_pc);
            if (a_hs) a_log.push_back(a_hs_data);
            if (b_hs) b_log.push_back(b_hs_data);
            if (chk_en) begin
                chk("a_valid", a_valid, m_mode[0] == 1);
                chk("a_busy", a_busy, m_mode[0] == 1);
                chk("a_done", a_done, m_mode[0] == 2);
                chk("a_overrun", a_ovr, m_ovr[0]);
                if (m_mode[0] == 1) chk("a_data", a_data, mfr[0][m_pos[0]]);
                if (a_hold) chk("a_data_stable", a_data, a_hs_data);
                chk("b_valid", b_valid, m_mode[1] == 1);
                chk("b_busy", b_busy, m_mode[1] == 1);
                chk("b_done", b_done, m_mode[1] == 2);
                chk("b_overrun", b_ovr, m_ovr[1]);
                if (m_mode[1] == 1) chk("b_data", b_data, mfr[1][m_pos[1]]);
                if (b_hold) chk("b_data_stable", b_data, b_hs_data);
            end
        end
    end

    task automatic wait_done(input int d, input int lim, input int rmode, output int at);
        logic r;
        at = -1;
        for (int i = 0; i < lim; i++) begin
            if ((d == 0) ? a_done : b_done) begin
                at = cyc;
                break;
            end
            if (rmode == 0) r = 1'b1;
            else if (rmode == 1) r = (i % 3 == 0);
            else r = 1'($urandom_range(0, 1));
            if (d == 0) a_rdy = r;
            else b_rdy = r;
            @(negedge clk);
        end
        if (d == 0) a_rdy = 1'b1;
        else b_rdy = 1'b1;
        if (at < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_a(input logic [15:0] snap, input logic [15:0] pc, output int t0);
        a_snap = snap;
        a_pc   = pc;
        a_trig = 1'b1;
        t0     = cyc;
        @(negedge clk);
        a_trig = 1'b0;
    endtask

    task automatic chk_a6(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                          input logic [7:0] e5);
        logic [7:0] e [6];
        #1;
        e = '{e0, e1, e2, e3, e4, e5};
        chk({nm, "_len"}, a_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < a_log.size()) chk(nm, a_log[i], e[i]);
        end
    endtask

    task automatic clear_logs();
        #1;
        a_log.delete();
        b_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int t0, at, dcnt, first_done, hdr2, ffcnt;
        logic ov1, ov2, seen;

        a_rst = 1'b0; a_trig = 1'b0; a_clr = 1'b0; a_rdy = 1'b1; a_snap = '0; a_pc = '0;
        b_rst = 1'b0; b_trig = 1'b0; b_clr = 1'b0; b_rdy = 1'b1; b_snap = '0; b_pc = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_overrun", a_ovr, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_valid", b_valid, 0);
        a_rst = 1'b1;
        b_rst = 1'b1;
        @(negedge clk);

        // Back-to-back frame, small config
        clear_logs();
        pulse_a(16'h1234, 16'h0040, t0);
        wait_done(0, 20, 0, at);
        chk("a_done_latency", at - t0, 7);
        chk("a_busy_in_done", a_busy, 0);
        chk_a6("a_frame_rdy1", 8'hA5, 8'h00, 8'h40, 8'h12, 8'h34, 8'h66);
        @(negedge clk);

        // Same frame with ready toggling 1,0,0
        clear_logs();
        pulse_a(16'h1234, 16'h0040, t0);
        wait_done(0, 40, 1, at);
        chk_a6("a_frame_toggle", 8'hA5, 8'h00, 8'h40, 8'h12, 8'h34, 8'h66);
        @(negedge clk);

        // Reset while the third byte is pending
        clear_logs();
        pulse_a(16'h1234, 16'h0040, t0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_pre_valid", a_valid, 1);
        chk("rst_mid_pre_data", a_data, 8'h40);
        a_rdy = 1'b0;
        a_rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", a_valid, 0);
        chk("rst_mid_busy", a_busy, 0);
        chk("rst_mid_done", a_done, 0);
        a_rst = 1'b1;
        a_rdy = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (a_done || a_valid) seen = 1'b1;
        end
        chk("rst_mid_no_done", seen, 0);
        clear_logs();
        pulse_a(16'h0304, 16'h0102, t0);
        wait_done(0, 20, 0, at);
        chk_a6("a_frame_after_rst", 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        @(negedge clk);

        // Trigger held high: repeating frames, overrun set mid-frame
        a_snap = 16'h1234;
        a_pc   = 16'h0040;
        a_trig = 1'b1;
        dcnt = 0; first_done = -1; hdr2 = -1; ov1 = 1'b0; ov2 = 1'b0;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            if (i == 1) ov1 = a_ovr;
            if (i == 2) ov2 = a_ovr;
            if (a_done) begin
                dcnt++;
                if (first_done < 0) first_done = cyc;
            end
            if (first_done >= 0 && hdr2 < 0 && a_valid) hdr2 = cyc;
        end
        a_trig = 1'b0;
        chk("hold_ovr_in_hdr_first", ov1, 0);
        chk("hold_ovr_set", ov2, 1);
        chk("hold_done_count", dcnt, 3);
        chk("hold_restart_gap", hdr2 - first_done, 2);
        wait_done(0, 20, 0, at);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        chk("hold_ovr_cleared", a_ovr, 0);

        // Default config, all-FF snapshot, inputs changed after capture
        clear_logs();
        b_snap = '1;
        b_pc   = 16'h0000;
        b_trig = 1'b1;
        t0     = cyc;
        @(negedge clk);
        b_trig = 1'b0;
        b_snap = {9{32'hDEADBEEF}};
        b_pc   = 16'h1234;
        repeat (6) @(negedge clk);
        b_trig = 1'b1;
        @(negedge clk);
        b_trig = 1'b0;
        chk("b_ovr_set_in_body", b_ovr, 1);
        b_clr  = 1'b1;
        b_trig = 1'b1;
        @(negedge clk);
        b_clr  = 1'b0;
        b_trig = 1'b0;
        chk("b_ovr_set_wins", b_ovr, 1);
        wait_done(1, 60, 0, at);
        chk("b_done_latency", at - t0, 41);
        chk("b_busy_in_done", b_busy, 0);
        #1;
        chk("b_frame_len", b_log.size(), 40);
        if (b_log.size() == 40) begin
            chk("b_hdr", b_log[0], 8'hA5);
            chk("b_pc_hi", b_log[1], 8'h00);
            chk("b_pc_lo", b_log[2], 8'h00);
            ffcnt = 0;
            for (int i = 3; i < 39; i++) if (b_log[i] == 8'hFF) ffcnt++;
            chk("b_ff_bytes", ffcnt, 36);
            chk("b_csum_ff", b_log[39], 8'h00);
        end
        @(negedge clk);
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        chk("b_ovr_clear_alone", b_ovr, 0);

        // Default config, counting bytes, random ready
        clear_logs();
        for (int i = 0; i < 36; i++) b_snap[287-8*i -: 8] = 8'(i + 1);
        b_pc   = 16'hBEEF;
        b_trig = 1'b1;
        @(negedge clk);
        b_trig = 1'b0;
        wait_done(1, 400, 2, at);
        #1;
        chk("b_cnt_len", b_log.size(), 40);
        if (b_log.size() == 40) begin
            chk("b_cnt_pc_hi", b_log[1], 8'hBE);
            chk("b_cnt_first", b_log[3], 8'h01);
            chk("b_cnt_last", b_log[38], 8'h24);
            chk("b_cnt_csum", b_log[39], 8'h75);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
